// File: rtl/cmp_ctrl_pkg.sv
// rtl/cmp_ctrl_pkg.sv - shared types and constants for the serial compare controller
package cmp_ctrl_pkg;

   localparam int DIGIT_W = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } cmpState_e;

   // CMP_NONE marks "no verdict yet" while digits are still being scanned
   localparam logic [1:0] CMP_NONE = 2'd0;
   localparam logic [1:0] CMP_EQ   = 2'd1;
   localparam logic [1:0] CMP_GT   = 2'd2;
   localparam logic [1:0] CMP_LT   = 2'd3;

endpackage

// File: rtl/cmp2_slice.sv
// rtl/cmp2_slice.sv - combinational unsigned compare of one 2-bit digit
module cmp2_slice
   import cmp_ctrl_pkg::*;
(
   input  logic [DIGIT_W-1:0] a,
   input  logic [DIGIT_W-1:0] b,
   output logic               eq,
   output logic               gt,
   output logic               lt
);

   assign eq = (a == b);
   assign gt = (a > b);
   assign lt = (a < b);

endmodule

// File: rtl/serial_cmp_ctrl.sv
// rtl/serial_cmp_ctrl.sv - MSB-first digit-serial magnitude compare controller
// EARLY_EXIT_EN: when defined, RUN ends at the first unequal digit.
module serial_cmp_ctrl
   import cmp_ctrl_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             eq,
   output logic             gt,
   output logic             lt
);

   localparam int NDIG  = WIDTH / DIGIT_W;
   localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NDIG - 1);

   cmpState_e          state, stateNext;
   logic [WIDTH-1:0]   aReg, bReg;
   logic [IDX_W-1:0]   idx;
   logic [1:0]         verdict, verdictNext;
   logic [DIGIT_W-1:0] digitA, digitB;
   logic               sliceEq, sliceGt, sliceLt;
   logic               capture;

   assign digitA = aReg[idx*DIGIT_W +: DIGIT_W];
   assign digitB = bReg[idx*DIGIT_W +: DIGIT_W];

   cmp2_slice uSlice (
      .a  (digitA),
      .b  (digitB),
      .eq (sliceEq),
      .gt (sliceGt),
      .lt (sliceLt)
   );

   always_comb begin
      stateNext   = state;
      verdictNext = verdict;
      capture     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               stateNext   = RUN;
               capture     = 1'b1;
               verdictNext = CMP_NONE;
            end
         end
         RUN: begin
            // only the first unequal digit decides; later digits cannot override it
            if (verdict == CMP_NONE && !sliceEq) begin
               verdictNext = sliceGt ? CMP_GT : CMP_LT;
`ifdef EARLY_EXIT_EN
               stateNext   = DONE;
`endif
            end
            if (idx == '0) begin
               stateNext = DONE;
               if (verdict == CMP_NONE && sliceEq)
                  verdictNext = CMP_EQ;
            end
         end
         DONE:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         aReg    <= '0;
         bReg    <= '0;
         idx     <= '0;
         verdict <= CMP_NONE;
      end else begin
         state   <= stateNext;
         verdict <= verdictNext;
         if (capture) begin
            aReg <= a;
            bReg <= b;
            idx  <= IDX_TOP;
         end else if (state == RUN && idx != '0) begin
            idx <= idx - 1'b1;
         end
      end
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);
   assign eq   = (verdict == CMP_EQ);
   assign gt   = (verdict == CMP_GT);
   assign lt   = (verdict == CMP_LT);

   // sliceLt is implied by !sliceEq && !sliceGt; kept on the slice for symmetry
   logic unusedLt;
   assign unusedLt = sliceLt;

endmodule

// File: tb/tb_serial_cmp_ctrl.sv
// tb/tb_serial_cmp_ctrl.sv - self-checking bench for serial_cmp_ctrl, WIDTH=8, either EARLY_EXIT_EN setting
module tb_serial_cmp_ctrl;

   localparam int W    = 8;
   localparam int NDIG = W / 2;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a, b;
   logic         busy, done, eq, gt, lt;

   int total = 0;
   int bad   = 0;

   serial_cmp_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .eq    (eq),
      .gt    (gt),
      .lt    (lt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected RUN length taken straight from the operand values
   function automatic int expLat(input logic [W-1:0] av, input logic [W-1:0] bv);
`ifdef EARLY_EXIT_EN
      logic [W-1:0] diff;
      diff = av ^ bv;
      if (diff != '0)
         for (int i = W - 1; i >= 0; i--)
            if (diff[i]) return NDIG - i / 2;
`endif
      return NDIG;
   endfunction

   // Entered at a negedge in IDLE; leaves at the negedge of the IDLE cycle after DONE
   task automatic doCompare(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                            input bit holdStart);
      int busyCnt;
      logic [2:0] expV;
      expV = {av == bv, av > bv, av < bv};
      a = av; b = bv; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (holdStart) begin
         a = 8'hFF; b = 8'h00;
      end else begin
         start = 1'b0;
         a = W'($urandom); b = W'($urandom);
      end
      check({tag, ".cleared"}, {29'd0, eq, gt, lt}, 32'd0);
      busyCnt = 0;
      while (busy && busyCnt < 40) begin
         busyCnt++;
         @(negedge clk);
      end
      start = 1'b0;
      check({tag, ".busyCycles"}, busyCnt, expLat(av, bv));
      check({tag, ".done"}, {31'd0, done}, 32'd1);
      check({tag, ".verdict"}, {29'd0, eq, gt, lt}, {29'd0, expV});
      @(negedge clk);
      check({tag, ".idle"}, {30'd0, busy, done}, 32'd0);
      check({tag, ".held"}, {29'd0, eq, gt, lt}, {29'd0, expV});
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      rst = 1'b1; start = 1'b0; a = '0; b = '0;
      repeat (2) @(negedge clk);
      check("reset.outputs", {27'd0, busy, done, eq, gt, lt}, 32'd0);
      rst = 1'b0;

      doCompare("t1.eq",      8'hA5, 8'hA5, 1'b0);
      doCompare("t2.gtMsb",   8'h80, 8'h7F, 1'b0);
      doCompare("t3.ltLsb",   8'h01, 8'h02, 1'b0);
      doCompare("t4.ignStart", 8'h10, 8'h20, 1'b1);
      doCompare("t6.backToBack", 8'hC0, 8'hC1, 1'b0);

      // reset while idle with a verdict held
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rstIdle.outputs", {27'd0, busy, done, eq, gt, lt}, 32'd0);

      // reset during the second RUN cycle
      a = 8'h30; b = 8'h00; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("t5.secondRunBusy", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("t5.afterReset", {27'd0, busy, done, eq, gt, lt}, 32'd0);
      doCompare("t5.fresh", 8'h03, 8'h03, 1'b0);

      for (int n = 0; n < 40; n++) begin
         ra = W'($urandom);
         case ($urandom_range(0, 2))
            0:       rb = ra;
            1:       rb = ra ^ (W'(1) << $urandom_range(0, W - 1));
            default: rb = W'($urandom);
         endcase
         doCompare($sformatf("rand%0d", n), ra, rb, ($urandom_range(0, 3) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
